// File: rtl/x_23k640_array_ctrl_pkg.sv
// Shared types and constants for the 23K640 SPI SRAM lane-array controller.
package x_23K640_pkg;

  localparam int ADDR_W = 16;

  localparam logic MODE_BYTE   = 1'b0;
  localparam logic MODE_STRIPE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/x_23k640_array_ctrl_lane_track.sv
// Per-lane bookkeeping: whether the lane has taken the current request,
// whether it has completed, and the read byte it returned.
module x_23K640_lane_track (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       issue_en,
  input  logic       track_en,
  input  logic       target,
  input  logic       accept,
  input  logic       ready,
  input  logic [7:0] rdata,
  output logic       lane_valid,
  output logic       accepted_nx,
  output logic       done_nx,
  output logic [7:0] rbyte
);

  logic accepted_q;
  logic done_q;
  logic capture;

  // A lane keeps requesting until it accepts; completion can land in the
  // same cycle as acceptance, so done is tracked independently.
  assign lane_valid  = issue_en & target & ~accepted_q;
  assign accepted_nx = accepted_q | (issue_en & target & accept);
  assign capture     = track_en & target & ready;
  assign done_nx     = done_q | capture;

  // Flags and read byte are wiped on every new request so stale data from
  // an earlier or aborted transfer can never leak into a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_q <= 1'b0;
      done_q     <= 1'b0;
      rbyte      <= 8'h00;
    end else if (clear) begin
      accepted_q <= 1'b0;
      done_q     <= 1'b0;
      rbyte      <= 8'h00;
    end else begin
      accepted_q <= accepted_nx;
      done_q     <= done_nx;
      if (capture) begin
        rbyte <= rdata;
      end
    end
  end

endmodule

// File: rtl/x_23k640_array_ctrl.sv
// Request controller for an array of 23K640 SPI SRAM lane engines: byte mode
// targets one lane, stripe mode broadcasts to all lanes, with a completion
// timeout and a held response handshake.
module x_23k640_array_ctrl
  import x_23K640_pkg::*;
#(
  parameter  int P_LANES   = 16,
  parameter  int P_TIMEOUT = 4096,
  localparam int P_LW      = $clog2(P_LANES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_rd_n_wr,
  input  logic                   i_req_mode,
  input  logic [ADDR_W+P_LW-1:0] i_req_addr,
  input  logic [8*P_LANES-1:0]   i_req_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic                   o_rsp_rd,
  output logic                   o_rsp_err,
  output logic [8*P_LANES-1:0]   o_rsp_data,
  output logic [P_LANES-1:0]     o_lane_valid,
  input  logic [P_LANES-1:0]     i_lane_accept,
  output logic                   o_lane_rd_n_wr,
  output logic [ADDR_W-1:0]      o_lane_addr,
  output logic [8*P_LANES-1:0]   o_lane_wdata,
  input  logic [P_LANES-1:0]     i_lane_ready,
  input  logic [8*P_LANES-1:0]   i_lane_rdata
);

  localparam int               CNT_W    = $clog2(P_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

  state_t                 state;
  state_t                 state_nx;
  logic                   accept;
  logic                   issue_en;
  logic                   track_en;
  logic                   all_acc;
  logic                   all_done;
  logic                   timed_out;
  logic                   rd_q;
  logic                   mode_q;
  logic                   err_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [8*P_LANES-1:0]   wdata_q;
  logic [8*P_LANES-1:0]   req_wdata;
  logic [P_LANES-1:0]     target_q;
  logic [P_LANES-1:0]     req_target;
  logic [P_LANES-1:0]     acc_nx;
  logic [P_LANES-1:0]     done_nx;
  logic [CNT_W-1:0]       cnt_q;
  logic [P_LW-1:0]        req_lane;
  logic [7:0]             rbyte [P_LANES];
  logic [7:0]             byte_or;

  assign req_lane    = i_req_addr[ADDR_W +: P_LW];
  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid & o_req_ready;
  assign issue_en    = (state == ISSUE);
  assign track_en    = issue_en | (state == WAIT);
  assign all_acc     = ((acc_nx & target_q) == target_q);
  assign all_done    = ((done_nx & target_q) == target_q);
  assign timed_out   = (state == WAIT) && (cnt_q == CNT_LAST) && !all_done;

  assign o_rsp_valid    = (state == RESP);
  assign o_rsp_rd       = o_rsp_valid & rd_q;
  assign o_rsp_err      = o_rsp_valid & err_q;
  assign o_lane_rd_n_wr = rd_q;
  assign o_lane_addr    = addr_q;
  assign o_lane_wdata   = wdata_q;

  // Decode an incoming request into its lane mask and per-lane write bytes;
  // byte mode leaves every other lane's write byte at zero.
  always_comb begin
    req_target = '0;
    req_wdata  = '0;
    if (i_req_mode == MODE_STRIPE) begin
      req_target = '1;
      req_wdata  = i_req_wdata;
    end else begin
      for (int k = 0; k < P_LANES; k++) begin
        if (req_lane == P_LW'(k)) begin
          req_target[k]        = 1'b1;
          req_wdata[8*k +: 8]  = i_req_wdata[7:0];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; when the last lane both accepts and completes in the
  // same ISSUE cycle we go straight to RESP so the response still follows
  // the final ready pulse by exactly one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (all_acc) begin
          state_nx = all_done ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (all_done || (cnt_q == CNT_LAST)) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Latch the request fields on acceptance; they drive the shared lane bus.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_q     <= 1'b0;
      mode_q   <= MODE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      target_q <= '0;
    end else if (accept) begin
      rd_q     <= i_req_rd_n_wr;
      mode_q   <= i_req_mode;
      addr_q   <= i_req_addr[ADDR_W-1:0];
      wdata_q  <= req_wdata;
      target_q <= req_target;
    end
  end

  // Completion timeout counter, running only while waiting on lanes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else if (state == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Error flag marks a response forced out by the timeout.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timed_out) begin
      err_q <= 1'b1;
    end
  end

  // Per-lane accept/done flags and read byte capture.
  for (genvar k = 0; k < P_LANES; k++) begin : g_lane
    x_23K640_lane_track u_track (
      .clk         (i_clk),
      .rst_n       (i_rst),
      .clear       (accept),
      .issue_en    (issue_en),
      .track_en    (track_en),
      .target      (target_q[k]),
      .accept      (i_lane_accept[k]),
      .ready       (i_lane_ready[k]),
      .rdata       (i_lane_rdata[8*k +: 8]),
      .lane_valid  (o_lane_valid[k]),
      .accepted_nx (acc_nx[k]),
      .done_nx     (done_nx[k]),
      .rbyte       (rbyte[k])
    );
  end

  // Assemble read data from the captured bytes; in byte mode only the
  // selected lane can hold a non-zero byte, so OR-ing them picks it out.
  always_comb begin
    byte_or    = 8'h00;
    o_rsp_data = '0;
    for (int k = 0; k < P_LANES; k++) begin
      byte_or = byte_or | rbyte[k];
    end
    if (o_rsp_valid && rd_q) begin
      if (mode_q == MODE_STRIPE) begin
        for (int k = 0; k < P_LANES; k++) begin
          o_rsp_data[8*k +: 8] = rbyte[k];
        end
      end else begin
        o_rsp_data[7:0] = byte_or;
      end
    end
  end

endmodule

// File: tb/tb_x_23k640_array_ctrl.sv
// Self-checking bench for the 23K640 lane-array controller.
module tb_x_23k640_array_ctrl;

  localparam int LANES = 16;
  localparam int TMO   = 64;

  typedef struct {
    logic         rd;
    logic         mode;
    logic [19:0]  addr;
    logic [127:0] wdata;
    logic [7:0]   rbase;
    logic [15:0]  exp_valid;
    logic [127:0] exp_lwd;
    logic [127:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_rd = 1'b0;
  logic         req_mode = 1'b0;
  logic [19:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_rd;
  logic         rsp_err;
  logic [127:0] rsp_data;
  logic [15:0]  lane_valid;
  logic [15:0]  lane_accept = '0;
  logic         lane_rd;
  logic [15:0]  lane_addr;
  logic [127:0] lane_wdata;
  logic [15:0]  lane_ready = '0;
  logic [127:0] lane_rdata = '0;

  int           total = 0;
  int           bad = 0;
  int           acc_delay [LANES];
  int           rdy_delay [LANES];
  logic [7:0]   rbytes [LANES];
  vec_t         vecs [6];

  always #5 clk = ~clk;

  x_23k640_array_ctrl #(
    .P_LANES   (LANES),
    .P_TIMEOUT (TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_rd_n_wr  (req_rd),
    .i_req_mode     (req_mode),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rd       (rsp_rd),
    .o_rsp_err      (rsp_err),
    .o_rsp_data     (rsp_data),
    .o_lane_valid   (lane_valid),
    .i_lane_accept  (lane_accept),
    .o_lane_rd_n_wr (lane_rd),
    .o_lane_addr    (lane_addr),
    .o_lane_wdata   (lane_wdata),
    .i_lane_ready   (lane_ready),
    .i_lane_rdata   (lane_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_lane_valid"}, 128'(lane_valid), 128'(0));
    check({tag, "_rsp_flags"}, 128'({rsp_rd, rsp_err, lane_rd}), 128'(0));
    check({tag, "_rsp_data"}, rsp_data, 128'(0));
    check({tag, "_lane_bus"}, lane_wdata | 128'(lane_addr), 128'(0));
  endtask

  // Spec-level reference: which lanes are targeted, what each lane must see
  // as write data, and what the response must carry given lane behaviour.
  function automatic void model(input logic rd, input logic mode, input logic [19:0] addr,
                                input logic [127:0] wdata, output logic [15:0] tgt,
                                output logic [127:0] lwd, output logic [127:0] data,
                                output logic err);
    int sel;
    sel  = int'(addr[19:16]);
    tgt  = mode ? 16'hFFFF : (16'h1 << sel);
    lwd  = mode ? wdata : (128'(wdata[7:0]) << (8 * sel));
    data = '0;
    err  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (tgt[k] && rdy_delay[k] < 0) err = 1'b1;
    end
    if (rd) begin
      if (mode) begin
        for (int k = 0; k < LANES; k++) begin
          data[8*k +: 8] = (rdy_delay[k] >= 0) ? rbytes[k] : 8'h00;
        end
      end else begin
        data[7:0] = (rdy_delay[sel] >= 0) ? rbytes[sel] : 8'h00;
      end
    end
  endfunction

  // Issue one request, play the lanes, check the response and hand it back.
  task automatic run_txn(input string tag, input logic rd, input logic mode,
                         input logic [19:0] addr, input logic [127:0] wdata,
                         input logic [15:0] exp_valid, input logic [127:0] exp_lwd,
                         input logic [127:0] exp_data, input logic exp_err,
                         input int bp_cycles, input int abort_at);
    int           c;
    int           last_rdy;
    int           last_acc;
    bit           got;
    bit           acc_done [LANES];
    bit           rdy_done [LANES];
    int           acc_cnt [LANES];
    int           rdy_cnt [LANES];
    logic [127:0] hold_data;
    logic [1:0]   hold_flags;
    for (int k = 0; k < LANES; k++) begin
      acc_done[k] = 0;
      rdy_done[k] = 0;
      acc_cnt[k]  = 0;
      rdy_cnt[k]  = 0;
    end
    check({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_rd    = rd;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    c = 0;
    last_rdy = -1;
    last_acc = -1;
    got = 0;
    while (c < 400) begin
      lane_accept = '0;
      lane_ready  = '0;
      lane_rdata  = {$urandom, $urandom, $urandom, $urandom};
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (c == 0) begin
        check({tag, "_lane_valid"}, 128'(lane_valid), 128'(exp_valid));
        check({tag, "_lane_wdata"}, lane_wdata, exp_lwd);
        check({tag, "_lane_addr"}, 128'({lane_rd, lane_addr}), 128'({rd, addr[15:0]}));
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        lane_rdata = '0;
        #1;
        check_reset_values({tag, "_in_reset"});
        step();
        step();
        check_reset_values({tag, "_held_reset"});
        rst_n = 1'b1;
        step();
        check({tag, "_after_release"}, 128'(req_ready), 128'(1));
        return;
      end
      for (int k = 0; k < LANES; k++) begin
        if (!exp_valid[k]) begin
          if ($urandom_range(0, 3) == 0) lane_ready[k] = 1'b1;
        end else if (acc_done[k]) begin
          if (!rdy_done[k] && rdy_delay[k] >= 0) begin
            if (rdy_cnt[k] == rdy_delay[k]) begin
              lane_ready[k]        = 1'b1;
              lane_rdata[8*k +: 8] = rbytes[k];
              rdy_done[k]          = 1;
              last_rdy             = c;
            end else begin
              rdy_cnt[k]++;
            end
          end
        end else if (lane_valid[k]) begin
          if (acc_cnt[k] == acc_delay[k]) begin
            lane_accept[k] = 1'b1;
            acc_done[k]    = 1;
            rdy_cnt[k]     = 1;
            last_acc       = c;
          end else begin
            acc_cnt[k]++;
          end
        end
      end
      step();
      c++;
    end
    lane_accept = '0;
    lane_ready  = '0;
    check({tag, "_rsp_arrived"}, 128'(got), 128'(1));
    if (got) begin
      if (exp_err) check({tag, "_timeout_cycle"}, 128'(c), 128'(last_acc + TMO + 1));
      else         check({tag, "_rsp_cycle"}, 128'(c), 128'(last_rdy + 1));
      check({tag, "_rsp_flags"}, 128'({rsp_rd, rsp_err}), 128'({rd, exp_err}));
      check({tag, "_rsp_data"}, rsp_data, exp_data);
      hold_data  = rsp_data;
      hold_flags = {rsp_rd, rsp_err};
      req_valid  = 1'b1;
      req_rd     = ~rd;
      req_mode   = ~mode;
      for (int i = 0; i < bp_cycles; i++) begin
        step();
        check({tag, "_hold_ctrl"}, 128'({req_ready, rsp_valid, rsp_rd, rsp_err}),
              128'({2'b01, hold_flags}));
        check({tag, "_hold_data"}, rsp_data, hold_data);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check({tag, "_rsp_taken"}, 128'({req_ready, rsp_valid}), 128'(2'b10));
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic rd, input logic mode,
                                input logic [19:0] addr, input logic [127:0] wdata,
                                input int bp_cycles, input int abort_at);
    logic [15:0]  tgt;
    logic [127:0] lwd;
    logic [127:0] data;
    logic         err;
    model(rd, mode, addr, wdata, tgt, lwd, data, err);
    run_txn(tag, rd, mode, addr, wdata, tgt, lwd, data, err, bp_cycles, abort_at);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 20'h3_0123, 128'hA5, 8'h00, 16'h0008,
                128'h0000_0000_0000_0000_0000_0000_a500_0000, 128'h0};
    vecs[1] = '{1'b1, 1'b0, 20'hF_1FFF, 128'h0, 8'h4B, 16'h8000, 128'h0, 128'h5A};
    vecs[2] = '{1'b0, 1'b0, 20'h9_ABCD, 128'hffffffff_ffffffff_ffffffff_ffffff3c, 8'h00,
                16'h0200, 128'h0000_0000_0000_3c00_0000_0000_0000_0000, 128'h0};
    vecs[3] = '{1'b1, 1'b0, 20'h0_0000, 128'h0, 8'h77, 16'h0001, 128'h0, 128'h77};
    vecs[4] = '{1'b1, 1'b1, 20'h5_4321, 128'h0, 8'h20, 16'hFFFF, 128'h0,
                128'h2f2e2d2c_2b2a2928_27262524_23222120};
    vecs[5] = '{1'b0, 1'b1, 20'h0_7FFF, 128'h0123456789abcdef_fedcba9876543210, 8'h00,
                16'hFFFF, 128'h0123456789abcdef_fedcba9876543210, 128'h0};

    #12;
    check_reset_values("reset");
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < LANES; k++) begin
        acc_delay[k] = k % 3;
        rdy_delay[k] = 1 + (k % 4);
        rbytes[k]    = vecs[v].rbase + 8'(k);
      end
      run_txn($sformatf("vec%0d", v), vecs[v].rd, vecs[v].mode, vecs[v].addr, vecs[v].wdata,
              vecs[v].exp_valid, vecs[v].exp_lwd, vecs[v].exp_data, 1'b0, 0, -1);
    end

    for (int k = 0; k < LANES; k++) begin
      acc_delay[k] = 0;
      rdy_delay[k] = 2 + ((k * 5) % 16) * 2;
      rbytes[k]    = 8'h10 + 8'(k);
    end
    run_txn("scramble", 1'b1, 1'b1, 20'h0_0100, 128'h0, 16'hFFFF, 128'h0,
            128'h1f1e1d1c_1b1a1918_17161514_13121110, 1'b0, 0, -1);

    for (int k = 0; k < LANES; k++) begin
      acc_delay[k] = k % 2;
      rdy_delay[k] = (k == 7) ? -1 : 2;
      rbytes[k]    = 8'hC0 + 8'(k);
    end
    apply_stimulus("timeout", 1'b0, 1'b1, 20'h0_2222, {4{32'hDEADBEEF}}, 0, -1);
    lane_ready[7]        = 1'b1;
    lane_rdata[63:56]    = 8'hEE;
    step();
    lane_ready = '0;
    check("late_ready_idle", 128'({req_ready, rsp_valid}), 128'(2'b10));
    for (int k = 0; k < LANES; k++) begin
      rdy_delay[k] = 1 + (k % 3);
      rbytes[k]    = 8'h30 + 8'(k);
    end
    apply_stimulus("after_timeout", 1'b1, 1'b1, 20'h0_3333, 128'h0, 0, -1);

    for (int k = 0; k < LANES; k++) begin
      acc_delay[k] = 1;
      rdy_delay[k] = 3;
      rbytes[k]    = 8'h60 + 8'(k);
    end
    apply_stimulus("backpressure", 1'b1, 1'b0, 20'h2_0042, 128'h0, 10, -1);

    for (int k = 0; k < LANES; k++) begin
      acc_delay[k] = 0;
      rdy_delay[k] = (k < 8) ? 2 : -1;
      rbytes[k]    = 8'h90 + 8'(k);
    end
    apply_stimulus("reset_wait", 1'b1, 1'b1, 20'h0_4444, 128'h0, 0, 10);
    for (int k = 0; k < LANES; k++) begin
      rdy_delay[k] = 1 + (k % 5);
      rbytes[k]    = 8'h80 + 8'(k);
    end
    apply_stimulus("after_reset", 1'b1, 1'b1, 20'h0_4444, 128'h0, 0, -1);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < LANES; k++) begin
        acc_delay[k] = $urandom_range(0, 3);
        rdy_delay[k] = $urandom_range(1, 6);
        rbytes[k]    = 8'($urandom);
      end
      apply_stimulus($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), 20'($urandom),
                     {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
